// File: rtl/pipelined_addsub_if.sv
// Handshake bundle for the pipelined adder/subtractor: an operand channel in,
// a result channel out, each with its own valid/ready pair.
interface pipelined_addsub_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is cut into STAGES
// chunks, one chunk added per cycle, with the carry registered in between.
module pipelined_addsub #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    pipelined_addsub_if.slave   bus
);
    localparam int CHUNK = WIDTH / STAGES;

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_c;
    logic [STAGES-1:0] nxt_c;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  s_q   [STAGES];
    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_s [STAGES];
    logic [WIDTH-1:0]  nxt_s [STAGES];
    logic [CHUNK:0]    part  [STAGES];

    // A stage may take new contents if it is empty or some stage downstream
    // of it (or the consumer) has room; the scan runs from the output back.
    always_comb begin
        logic run;
        adv = '0;
        run = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            run    = run || !v_q[k];
            adv[k] = run;
        end
    end

    // Stage 0 sees the raw operands with b inverted for subtraction; every
    // later stage sees its predecessor's registers and adds its own chunk.
    always_comb begin
        src_v    = '0;
        src_c    = '0;
        nxt_c    = '0;
        src_v[0] = bus.in_valid;
        src_a[0] = bus.a;
        src_b[0] = bus.sub ? ~bus.b : bus.b;
        src_c[0] = bus.sub ? ~bus.cin : bus.cin;
        src_s[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k] = v_q[k-1];
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_c[k] = c_q[k-1];
            src_s[k] = s_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            part[k]  = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                     + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, src_c[k]};
            nxt_c[k] = part[k][CHUNK];
            nxt_s[k] = src_s[k];
            nxt_s[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
        end
    end

    // Data registers load only with a valid op so a stalled or idle stage
    // keeps its contents and undriven operands never enter the pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    v_q[k] <= src_v[k];
                    if (src_v[k]) begin
                        a_q[k] <= src_a[k];
                        b_q[k] <= src_b[k];
                        s_q[k] <= nxt_s[k];
                        c_q[k] <= nxt_c[k];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = adv[0];
    assign bus.out_valid = v_q[STAGES-1];
    assign bus.sum       = s_q[STAGES-1];
    assign bus.cout      = c_q[STAGES-1];
    assign bus.ovf       = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1])
                        && (s_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
endmodule
